// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Multi-port architectural register file: NUM_READ registered read ports,
// two write ports (w1 has priority over w0 on an address collision) and a
// clear sequencer that sweeps zeros through every entry after reset or on a
// clear_req pulse. Reads are write-first: a read hitting an enabled write at
// the same edge returns the data being written.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset (restarts the clear sweep)
//   r_addr     in   packed read addresses, port i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   r_data     out  packed read data, port i = [i*DATA_WIDTH +: DATA_WIDTH]
//   w0_en      in   write port 0 enable
//   w0_addr    in   write port 0 address
//   w0_data    in   write port 0 data
//   w1_en      in   write port 1 enable (wins over w0 on same address)
//   w1_addr    in   write port 1 address
//   w1_data    in   write port 1 data
//   clear_req  in   single-cycle pulse, starts a clear sweep when idle
//   busy       out  high while a clear sweep is running
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_READ   = 2,
  parameter bit          ZERO_REG   = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
  input  logic                           w0_en,
  input  logic [ADDR_WIDTH-1:0]          w0_addr,
  input  logic [DATA_WIDTH-1:0]          w0_data,
  input  logic                           w1_en,
  input  logic [ADDR_WIDTH-1:0]          w1_addr,
  input  logic [DATA_WIDTH-1:0]          w1_data,
  input  logic                           clear_req,
  output logic                           busy
);

  localparam int unsigned           DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic                  w_sweep;

  logic                  w_w0_ok;
  logic                  w_w1_ok;

  logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] w_rd_next;

  // -------------------------------------------------------------------------
  // Clear sequencer: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StClear;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Clear sequencer: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (clear_req) begin
          w_state_next = StClear;
          w_idx_next   = '0;
        end
      end
      StClear: begin
        // Index wraps back to 0 after the last entry; clear_req is ignored here.
        w_idx_next = r_idx + ADDR_WIDTH'(1);
        if (r_idx == LAST_IDX) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StClear;
        w_idx_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Clear sequencer: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_sweep = (r_state == StClear);
    busy    = w_sweep;
  end

  // Effective write enables: blocked during a sweep and, with ZERO_REG, for
  // entry 0. These gated enables drive both the array and the bypass path so
  // a dropped write can never leak through the bypass.
  assign w_w0_ok = w0_en && !w_sweep && !(ZERO_REG && (w0_addr == '0));
  assign w_w1_ok = w1_en && !w_sweep && !(ZERO_REG && (w1_addr == '0));

  // -------------------------------------------------------------------------
  // Storage array (no reset; the sweep initialises it)
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_sweep) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_w0_ok) begin
        r_mem[w0_addr] <= w0_data;
      end
      // Issued after w0 so w1 wins on an address collision.
      if (w_w1_ok) begin
        r_mem[w1_addr] <= w1_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path: write-first bypass, w1 before w0, then array
  // -------------------------------------------------------------------------
  always_comb begin
    w_rd_next = '0;
    if (!w_sweep) begin
      for (int i = 0; i < int'(NUM_READ); i++) begin
        if (w_w1_ok && (w1_addr == r_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = w1_data;
        end else if (w_w0_ok && (w0_addr == r_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = w0_data;
        end else if (ZERO_REG && (r_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
          w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin
          w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  // Fresh read every cycle; forced to zero for the whole sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else begin
      r_data <= w_rd_next;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NR  = 2;
  localparam int ZAW = 4;

  localparam int KRd    = 0;
  localparam int KBusy  = 1;
  localparam int KZRd   = 2;
  localparam int KZBusy = 3;

  logic clk = 1'b0;
  logic rst;

  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;
  logic             w0_en, w1_en, clear_req, busy;
  logic [AW-1:0]    w0_addr, w1_addr;
  logic [DW-1:0]    w0_data, w1_data;

  logic [NR*ZAW-1:0] zr_addr;
  logic [NR*DW-1:0]  zr_data;
  logic              zw0_en, zw1_en, zclear, zbusy;
  logic [ZAW-1:0]    zw0_addr, zw1_addr;
  logic [DW-1:0]     zw0_data, zw1_data;

  typedef struct {
    int    kind;
    int    port;
    int    exp;
    int    due;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  reg_file_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .ZERO_REG(1'b0)
  ) dut (
    .clock(clk), .reset(rst), .r_addr(r_addr), .r_data(r_data),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .clear_req(clear_req), .busy(busy)
  );

  reg_file_mp #(
    .ADDR_WIDTH(ZAW), .DATA_WIDTH(DW), .NUM_READ(NR), .ZERO_REG(1'b1)
  ) dut_z (
    .clock(clk), .reset(rst), .r_addr(zr_addr), .r_data(zr_data),
    .w0_en(zw0_en), .w0_addr(zw0_addr), .w0_data(zw0_data),
    .w1_en(zw1_en), .w1_addr(zw1_addr), .w1_data(zw1_data),
    .clear_req(zclear), .busy(zbusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind, input int port);
    logic [31:0] v;
    v = '0;
    case (kind)
      KRd:    v = 32'(r_data[port*DW +: DW]);
      KBusy:  v = 32'(busy);
      KZRd:   v = 32'(zr_data[port*DW +: DW]);
      default: v = 32'(zbusy);
    endcase
    return v;
  endfunction

  // Monitor: outputs are sampled on the falling edge; every expectation due
  // in this cycle is popped and compared.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [31:0] act;
        act = actual(sb[i].kind, sb[i].port);
        checks++;
        if (act !== 32'(sb[i].exp)) begin
          errors++;
          $display("FAIL %s cycle %0d got 0x%0h expected 0x%0h",
                   sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int kind, input int port, input int exp, input int ofs,
                           input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    e.due  = cyc + ofs;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_rd(input int p0, input int p1, input string name);
    expect_at(KRd, 0, p0, 1, {name, "_p0"});
    expect_at(KRd, 1, p1, 1, {name, "_p1"});
  endtask

  task automatic exp_zrd(input int p0, input int p1, input string name);
    expect_at(KZRd, 0, p0, 1, {name, "_p0"});
    expect_at(KZRd, 1, p1, 1, {name, "_p1"});
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    w0_en = 1'b0; w1_en = 1'b0; clear_req = 1'b0;
    zw0_en = 1'b0; zw1_en = 1'b0; zclear = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1);
    r_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic zrd(input int a0, input int a1);
    zr_addr = {ZAW'(a1), ZAW'(a0)};
  endtask

  task automatic wr0(input int a, input int d);
    w0_en = 1'b1; w0_addr = AW'(a); w0_data = DW'(d);
  endtask

  task automatic wr1(input int a, input int d);
    w1_en = 1'b1; w1_addr = AW'(a); w1_data = DW'(d);
  endtask

  // Counts falling edges with busy high, starting at the current one.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b1;
    idle_in();
    r_addr = '0; w0_addr = '0; w0_data = '0; w1_addr = '0; w1_data = '0;
    zr_addr = '0; zw0_addr = '0; zw0_data = '0; zw1_addr = '0; zw1_data = '0;
    tick();
    tick();

    // Reset state
    expect_at(KBusy, 0, 1, 1, "rst_busy");
    exp_rd(0, 0, "rst_rdata");
    expect_at(KZBusy, 0, 1, 1, "z_rst_busy");
    tick();

    // 1: sweep after reset lasts DEPTH cycles
    rst = 1'b0;
    expect_at(KBusy, 0, 1, 1, "sweep_busy_first");
    expect_at(KBusy, 0, 1, 255, "sweep_busy_last");
    expect_at(KBusy, 0, 0, 256, "sweep_busy_fall");
    expect_at(KZBusy, 0, 1, 15, "z_sweep_busy_last");
    expect_at(KZBusy, 0, 0, 16, "z_sweep_busy_fall");
    count_busy(n);
    check_int("sweep_len", n, 256);

    for (int a = 0; a < 256; a += 2) begin
      rd(a, a + 1);
      exp_rd(0, 0, "post_sweep_zero");
      zrd(a % 16, (a + 1) % 16);
      exp_zrd(0, 0, "z_post_sweep_zero");
      tick();
    end

    // 2: simple write then read
    idle_in(); wr0(5, 'hA5); rd(0, 1); exp_rd(0, 0, "t2_before");
    tick();
    idle_in(); rd(5, 0); exp_rd('hA5, 0, "t2_read5");
    tick();

    // 3: collision (w1 wins) with bypass, then stored value
    idle_in(); wr0(9, 'h11); wr1(9, 'h22); rd(5, 9); exp_rd('hA5, 'h22, "t3_bypass");
    tick();
    idle_in(); rd(9, 5); exp_rd('h22, 'hA5, "t3_stored");
    tick();
    idle_in(); wr0(20, 'h20); wr1(21, 'h21); rd(20, 21); exp_rd('h20, 'h21, "t3_dual_bypass");
    tick();
    idle_in(); rd(21, 20); exp_rd('h21, 'h20, "t3_dual_stored");
    tick();
    idle_in(); wr0(0, 'h77); wr1(255, 'hEE); rd(255, 0); exp_rd('hEE, 'h77, "t3_edges_bypass");
    tick();
    idle_in(); rd(0, 255); exp_rd('h77, 'hEE, "t3_edges_stored");
    tick();
    idle_in(); wr0(30, 'h5A); rd(30, 30); exp_rd('h5A, 'h5A, "t3_w0_bypass");
    tick();

    // 4: ZERO_REG instance
    idle_in(); zw1_en = 1'b1; zw1_addr = 4'd0; zw1_data = 8'hFF;
    zw0_en = 1'b1; zw0_addr = 4'd1; zw0_data = 8'h3C;
    zrd(0, 1); exp_zrd(0, 'h3C, "t4_zero_bypass");
    tick();
    idle_in(); zrd(1, 0); exp_zrd('h3C, 0, "t4_zero_stored");
    tick();
    idle_in(); zw0_en = 1'b1; zw0_addr = 4'd0; zw0_data = 8'hAA;
    zrd(0, 0); exp_zrd(0, 0, "t4_w0_zero_bypass");
    tick();
    idle_in(); zrd(0, 1); exp_zrd(0, 'h3C, "t4_w0_zero_stored");
    tick();

    // 5: requested clear, writes ignored, r_data held at zero
    idle_in(); wr0(3, 'h33); rd(3, 3); exp_rd('h33, 'h33, "t5_fill");
    tick();
    idle_in(); clear_req = 1'b1; rd(3, 4); exp_rd('h33, 0, "t5_req_edge_read");
    expect_at(KBusy, 0, 1, 1, "t5_busy_first");
    expect_at(KBusy, 0, 1, 256, "t5_busy_last");
    expect_at(KBusy, 0, 0, 257, "t5_busy_fall");
    tick();
    for (int j = 1; j <= 256; j++) begin
      idle_in(); rd(3, 4);
      if (j <= 3 || j == 256) wr0(4, 'h44);
      if (j == 100) clear_req = 1'b1;
      exp_rd(0, 0, "t5_sweep_rdata");
      tick();
    end
    idle_in(); rd(3, 4); exp_rd(0, 0, "t5_after_clear");
    tick();

    // 6: reset mid-sweep restarts from index 0
    idle_in(); wr0(200, 'h99);
    tick();
    idle_in(); clear_req = 1'b1;
    tick();
    idle_in();
    for (int j = 0; j < 100; j++) tick();
    rst = 1'b1;
    expect_at(KBusy, 0, 1, 1, "t6_busy_in_reset");
    exp_rd(0, 0, "t6_rdata_in_reset");
    tick();
    tick();
    rst = 1'b0;
    expect_at(KBusy, 0, 1, 255, "t6_busy_last");
    expect_at(KBusy, 0, 0, 256, "t6_busy_fall");
    expect_at(KZBusy, 0, 0, 16, "t6_z_busy_fall");
    count_busy(n);
    check_int("t6_sweep_len", n, 256);
    idle_in(); rd(200, 5); exp_rd(0, 0, "t6_cleared");
    tick();
    idle_in(); wr1(7, 'hC7); rd(7, 7); exp_rd('hC7, 'hC7, "t6_post_write");
    tick();
    idle_in(); rd(7, 200); exp_rd('hC7, 0, "t6_post_read");
    tick();
    tick();
    tick();
    k = sb.size();
    check_int("scoreboard_drained", k, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
